// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: synchroniser, tick divider, false-start rejection, error flags.
// Optional feature: define UART_RX_MAJORITY_EN to vote 2-of-3 over samples MID-1..MID+1.
module uart_rx_param #(
    parameter int unsigned DATA_BITS       = 8,
    parameter int unsigned OVERSAMPLING    = 16,
    parameter int unsigned CLKS_PER_SAMPLE = 27,
    parameter int unsigned PARITY          = 0,
    parameter int unsigned STOP_BITS       = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);
    localparam int unsigned SCW = $clog2(OVERSAMPLING) + 1;
    localparam int unsigned DW  = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int unsigned IW  = $clog2(DATA_BITS + 1);
    localparam int unsigned MID = OVERSAMPLING / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned SAMP = MID + 1;
`else
    localparam int unsigned SAMP = MID;
`endif
    localparam logic [SCW-1:0] SC_SAMP = SCW'(SAMP);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLING - 1);
    localparam logic           SB_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic                 rx_meta, rx_s;
    logic [DW-1:0]        div;
    logic                 tick;
    logic [2:0]           state, state_n;
    logic [SCW-1:0]       sc, sc_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n, out_n;
    logic                 sb, sb_n;
    logic                 armed, armed_n;
    logic                 ferr_p, ferr_n, perr_p, perr_n;
    logic                 valid_n, frame_err_n, parity_err_n;
    logic                 samp_bit;

    assign tick = (div == DW'(CLKS_PER_SAMPLE - 1));

`ifdef UART_RX_MAJORITY_EN
    logic m0, m1;
    assign samp_bit = (m0 & m1) | (m0 & rx_s) | (m1 & rx_s);
`else
    assign samp_bit = rx_s;
`endif

    // Next-state and datapath; every decision is qualified by tick
    always_comb begin
        state_n      = state;
        sc_n         = sc;
        idx_n        = idx;
        shift_n      = shift;
        sb_n         = sb;
        armed_n      = armed;
        ferr_n       = ferr_p;
        perr_n       = perr_p;
        out_n        = out;
        valid_n      = 1'b0;
        frame_err_n  = frame_err;
        parity_err_n = parity_err;
        if (tick) begin
            sc_n = sc + SCW'(1);
            case (state)
                IDLE: begin
                    sc_n = '0;
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                        sc_n    = SCW'(1);
                        idx_n   = '0;
                        sb_n    = 1'b0;
                        ferr_n  = 1'b0;
                        perr_n  = 1'b0;
                    end
                end
                START: begin
                    if (sc == SC_LAST) begin
                        state_n = DATA;
                        sc_n    = '0;
                    end
                    if (sc == SC_SAMP && samp_bit) begin
                        state_n = IDLE;
                        sc_n    = '0;
                    end
                end
                DATA: begin
                    if (sc == SC_SAMP) begin
                        shift_n = {samp_bit, shift[DATA_BITS-1:1]};
                        idx_n   = idx + IW'(1);
                    end
                    if (sc == SC_LAST) begin
                        sc_n = '0;
                        if (idx_n == IW'(DATA_BITS))
                            state_n = (PARITY != 0) ? PAR : STOP;
                    end
                end
                PAR: begin
                    if (sc == SC_SAMP)
                        perr_n = (PARITY == 1) ? ~(^shift ^ samp_bit) : (^shift ^ samp_bit);
                    if (sc == SC_LAST) begin
                        state_n = STOP;
                        sc_n    = '0;
                    end
                end
                STOP: begin
                    if (sc == SC_LAST) begin
                        sc_n = '0;
                        sb_n = sb + 1'b1;
                    end
                    // Last stop bit exits at mid-bit, leaving margin for a back-to-back start
                    if (sc == SC_SAMP) begin
                        if (!samp_bit)
                            ferr_n = 1'b1;
                        if (sb == SB_LAST) begin
                            state_n      = IDLE;
                            sc_n         = '0;
                            armed_n      = 1'b0;
                            out_n        = shift;
                            valid_n      = 1'b1;
                            frame_err_n  = ferr_p | ~samp_bit;
                            parity_err_n = perr_p;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    sc_n    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            div        <= '0;
            state      <= IDLE;
            sc         <= '0;
            idx        <= '0;
            shift      <= '0;
            sb         <= 1'b0;
            armed      <= 1'b1;
            ferr_p     <= 1'b0;
            perr_p     <= 1'b0;
            out        <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_s       <= rx_meta;
            div        <= tick ? '0 : div + DW'(1);
            state      <= state_n;
            sc         <= sc_n;
            idx        <= idx_n;
            shift      <= shift_n;
            sb         <= sb_n;
            armed      <= armed_n;
            ferr_p     <= ferr_n;
            perr_p     <= perr_n;
            out        <= out_n;
            valid      <= valid_n;
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
            busy       <= (state_n != IDLE);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Vote samples ahead of the decision point
    always_ff @(posedge clk) begin
        if (rst) begin
            m0 <= 1'b1;
            m1 <= 1'b1;
        end else if (tick) begin
            if (sc == SCW'(MID - 1)) m0 <= rx_s;
            if (sc == SCW'(MID))     m1 <= rx_s;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E1 instance, 4 clk/tick, 16 ticks/bit.
module tb_uart_rx_param;
    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        int         gap;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_p;
    logic [7:0] out_a, out_p;
    logic       valid_a, valid_p, ferr_a, ferr_p, perr_a, perr_p, busy_a, busy_p;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    clk_cnt  = 0;
    int    last_a   = 0;
    int    last_p   = 0;
    int    busy_cnt_a = 0;
    logic  va_prev  = 1'b0;
    logic  vp_prev  = 1'b0;
    item_t q_a[$];
    item_t q_p[$];
    item_t it_a, it_p;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [7:0] MAJ_EXP = 8'hFF;
`else
    localparam logic [7:0] MAJ_EXP = 8'hF7;
`endif

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLING(16), .CLKS_PER_SAMPLE(4), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .out(out_a), .valid(valid_a),
        .frame_err(ferr_a), .parity_err(perr_a), .busy(busy_a));

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLING(16), .CLKS_PER_SAMPLE(4), .PARITY(2), .STOP_BITS(1)) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .out(out_p), .valid(valid_p),
        .frame_err(ferr_p), .parity_err(perr_p), .busy(busy_p));

    always #5 clk = ~clk;

    // cyc == k right after the k-th edge following reset release; ticks act on edges with k%4==0
    always @(posedge clk) begin
        clk_cnt <= clk_cnt + 1;
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic check_item(input string tag, input item_t it, input logic [7:0] d,
                              input logic fe, input logic pe, input int gap);
        cmp({tag, "_data"}, 32'(d), 32'(it.data));
        cmp({tag, "_frame_err"}, 32'(fe), 32'(it.ferr));
        cmp({tag, "_parity_err"}, 32'(pe), 32'(it.perr));
        if (it.gap != 0) cmp({tag, "_valid_gap"}, gap, it.gap);
    endtask

    // Monitors: pop the scoreboard whenever a receiver strobes valid
    always @(negedge clk) begin
        if (rst) begin
            va_prev = 1'b0;
        end else begin
            if (busy_a) busy_cnt_a++;
            if (va_prev) cmp("a_busy_after_valid", 32'(busy_a), 0);
            if (valid_a) begin
                cmp("a_valid_width", 32'(va_prev), 0);
                cmp("a_expected_pending", 32'(q_a.size() > 0), 1);
                if (q_a.size() > 0) begin
                    it_a = q_a.pop_front();
                    check_item("a", it_a, out_a, ferr_a, perr_a, clk_cnt - last_a);
                end
                last_a = clk_cnt;
            end
            va_prev = valid_a;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            vp_prev = 1'b0;
        end else begin
            if (vp_prev) cmp("p_busy_after_valid", 32'(busy_p), 0);
            if (valid_p) begin
                cmp("p_valid_width", 32'(vp_prev), 0);
                cmp("p_expected_pending", 32'(q_p.size() > 0), 1);
                if (q_p.size() > 0) begin
                    it_p = q_p.pop_front();
                    check_item("p", it_p, out_p, ferr_p, perr_p, clk_cnt - last_p);
                end
                last_p = clk_cnt;
            end
            vp_prev = valid_p;
        end
    end

    task automatic wait_clk(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic align();
        while (cyc % 4 != 1) wait_clk(1);
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_p = v;
    endtask

    task automatic push(input int sel, input logic [7:0] d, input logic fe, input logic pe, input int gap);
        item_t it;
        it.data = d; it.ferr = fe; it.perr = pe; it.gap = gap;
        if (sel == 0) q_a.push_back(it);
        else          q_p.push_back(it);
    endtask

    // One frame, 64 clk per bit; glitch_bit>=0 pulls that data bit low for 4 clk at its mid-point
    task automatic send(input int sel, input logic [7:0] d, input bit use_par, input logic par_b,
                        input logic stop_b, input int glitch_bit, input int idle_bits);
        drive(sel, 1'b0);
        wait_clk(64);
        for (int i = 0; i < 8; i++) begin
            drive(sel, d[i]);
            if (i == glitch_bit) begin
                wait_clk(32);
                drive(sel, 1'b0);
                wait_clk(4);
                drive(sel, d[i]);
                wait_clk(28);
            end else begin
                wait_clk(64);
            end
        end
        if (use_par) begin
            drive(sel, par_b);
            wait_clk(64);
        end
        drive(sel, stop_b);
        wait_clk(64);
        drive(sel, 1'b1);
        wait_clk(64 * idle_bits);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc;
        rst  = 1'b1;
        rx_a = 1'b1;
        rx_p = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(2);

        cmp("reset_out_a", 32'(out_a), 0);
        cmp("reset_valid_a", 32'(valid_a), 0);
        cmp("reset_ferr_a", 32'(ferr_a), 0);
        cmp("reset_perr_a", 32'(perr_a), 0);
        cmp("reset_busy_a", 32'(busy_a), 0);
        cmp("reset_out_p", 32'(out_p), 0);
        cmp("reset_perr_p", 32'(perr_p), 0);

        // Clean 8N1 frame
        push(0, 8'hA5, 1'b0, 1'b0, 0);
        align();
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 2);

        // 3-tick low glitch: busy pulses, no frame delivered
        bc = busy_cnt_a;
        align();
        drive(0, 1'b0);
        wait_clk(12);
        drive(0, 1'b1);
        wait_clk(256);
        cmp("glitch_busy_seen", 32'(busy_cnt_a > bc), 1);
        cmp("glitch_out_held", 32'(out_a), 32'h A5);
        cmp("glitch_busy_idle", 32'(busy_a), 0);

        // Framing error, then a clean frame clears it
        push(0, 8'h3C, 1'b1, 1'b0, 0);
        align();
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, 2);
        push(0, 8'h01, 1'b0, 1'b0, 0);
        send(0, 8'h01, 1'b0, 1'b0, 1'b1, -1, 2);
        cmp("ferr_held", 32'(ferr_a), 0);

        // Even parity: 0x07 has odd weight, so parity bit 0 is an error and 1 is not
        push(1, 8'h07, 1'b0, 1'b1, 0);
        align();
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, -1, 2);
        push(1, 8'h07, 1'b0, 1'b0, 0);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, -1, 2);

        // Back-to-back frames, valids exactly one frame (640 clk) apart
        push(0, 8'h55, 1'b0, 1'b0, 0);
        push(0, 8'hAA, 1'b0, 1'b0, 640);
        align();
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, -1, 0);
        send(0, 8'hAA, 1'b0, 1'b0, 1'b1, -1, 0);

        // Third frame aborted by reset in bit 2
        drive(0, 1'b0); wait_clk(64);
        drive(0, 1'b1); wait_clk(64);
        drive(0, 1'b1); wait_clk(64);
        drive(0, 1'b0); wait_clk(32);
        rst = 1'b1;
        drive(0, 1'b1);
        wait_clk(3);
        cmp("midrst_out", 32'(out_a), 0);
        cmp("midrst_valid", 32'(valid_a), 0);
        cmp("midrst_ferr", 32'(ferr_a), 0);
        cmp("midrst_perr", 32'(perr_a), 0);
        cmp("midrst_busy", 32'(busy_a), 0);
        cmp("midrst_out_p", 32'(out_p), 0);
        rst = 1'b0;
        wait_clk(128);
        cmp("postrst_busy", 32'(busy_a), 0);
        push(0, 8'h81, 1'b0, 1'b0, 0);
        align();
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, -1, 2);

        // Break: exactly one all-zero frame with framing error, then recovery
        push(0, 8'h00, 1'b1, 1'b0, 0);
        align();
        drive(0, 1'b0);
        wait_clk(64 * 15);
        drive(0, 1'b1);
        wait_clk(128);
        push(0, 8'h42, 1'b0, 1'b0, 0);
        align();
        send(0, 8'h42, 1'b0, 1'b0, 1'b1, -1, 2);

        // One-tick glitch at mid of bit 3
        push(0, MAJ_EXP, 1'b0, 1'b0, 0);
        align();
        send(0, 8'hFF, 1'b0, 1'b0, 1'b1, 3, 2);

        for (int i = 0; i < 2000 && (q_a.size() > 0 || q_p.size() > 0); i++) wait_clk(1);
        cmp("drain_a", 32'(q_a.size()), 0);
        cmp("drain_p", 32'(q_p.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
